pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline-stage register, the next generation of our fixed-field stage registers (IF/ID, ID/EX, EX/MEM).
- Carries a generic control vector, data vector and destination-register field between two stages.
- Uses a valid/ready handshake, with an optional 2-entry skid buffer so backpressure does not combinationally reach the upstream stage.
- Flush inserts a bubble by zeroing control and rd while keeping data.
- Exposes a saturating bubble counter for performance monitoring.

Parameters:
CTRL_W, 16, width of control vector (RegWrite, MemWrite, Branch, ALUControl, ...)
DATA_W, 160, width of data payload (pc, operands, imm, funct3, PCPlus4, ...)
RD_W, 5, width of destination register field
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  bubble request from hazard_unit
in_valid  in  1  upstream stage holds a valid instruction
in_ready  out  1  this stage can accept this cycle
in_ctrl  in  CTRL_W  control bits from upstream
in_data  in  DATA_W  data payload from upstream
in_rd  in  RD_W  destination register from upstream
out_valid  out  1  M entry valid
out_ready  in  1  downstream accepts this cycle
out_ctrl  out  CTRL_W  control to downstream
out_data  out  DATA_W  data to downstream
out_rd  out  RD_W  destination register to downstream
bubble_count  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Storage: main entry M = {v, ctrl, data, rd}, which drives the out_* ports directly. Skid entry S = {v, ctrl, data, rd} exists only when SKID=1.
- Handshakes: accept = in_valid & in_ready; drain = out_valid & out_ready. Upstream must hold its inputs stable while in_valid=1 and in_ready=0.
- in_ready:
  - SKID=1: in_ready = !S.v & !flush.
  - SKID=0: in_ready = (!M.v | out_ready) & !flush.
- Invariant: out_ctrl = 0 and out_rd = 0 whenever out_valid = 0, so a bubble never writes or forwards.
- Reset (rst=1 at posedge):
  - M.v = S.v = 0; all ctrl, rd and data fields = 0; bubble_count = 0.
  - Outputs read 0 in the cycle after reset.
- Update rules at each posedge, evaluated in priority order:
  1. rst.
  2. flush: M.v = S.v = 0, ctrl = 0, rd = 0 in both entries; data fields keep their old values; no accept this cycle (in_ready is 0).
  3. Otherwise:
     - S.v & drain: S moves to M; S.v = 0.
     - !S.v & accept & (!M.v | drain): input loads into M.
     - !S.v & accept & M.v & !drain: input loads into S (SKID=1 only; impossible with SKID=0).
     - drain & no refill: M.v = 0, M.ctrl = 0, M.rd = 0.
     - Otherwise: hold.
- Latency: 1 cycle from accept to out_valid when M is empty. Throughput: 1 per cycle when out_ready is held high.
- Ordering: strictly FIFO; S always holds the younger entry.
- Simultaneous events:
  - flush overrides accept and drain. The drain handshake of the current M entry still counts downstream, since it is sampled the same edge.
  - Accept and drain on the same edge with M full and S empty: the new entry replaces M.
- bubble_count: increments at the edge when out_ready=1 and out_valid=0; saturates at 2^CNT_W-1; does not wrap; cleared only by rst.
- Mid-operation reset: any in-flight M/S contents are discarded; in_ready reads 1 the cycle after rst deasserts.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_ctrl=0, out_rd=0, bubble_count=0; in_ready=1 the first cycle after release.
- Streaming: out_ready=1, send ctrl=0x0001..0x0004, rd=1..4 back-to-back → outputs appear 1 cycle later in order, with no gaps and in_ready constant 1.
- Backpressure (SKID=1): out_ready=0 while sending A, B, C → M=A, S=B, in_ready=0 from the cycle after B, C held upstream. Raise out_ready → A, B, C drain in order over 3 consecutive cycles.
- Flush: M=A (rd=7, ctrl=0xFFFF) and S=B, then pulse flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0, out_rd=0, out_data=A's data, S empty, input not consumed.
- Bubble counter (CNT_W=4): out_ready=1 and in_valid=0 for 20 cycles → bubble_count reaches 15 and stays at 15.
- SKID=0 build: out_ready=0 with M full → in_ready=0 in the same cycle. Raise out_ready and in_valid together → in_ready=1 combinationally and M is replaced on that edge.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline-stage register: valid/ready handshake with an optional
// 2-entry skid buffer, flush-to-bubble and a saturating bubble counter.
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int RD_W   = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              m_vld_p0;
  logic [CTRL_W-1:0] m_ctrl_p0;
  logic [DATA_W-1:0] m_data_p0;
  logic [RD_W-1:0]   m_rd_p0;

  logic              s_vld_p0;
  logic [CTRL_W-1:0] s_ctrl_p0;
  logic [DATA_W-1:0] s_data_p0;
  logic [RD_W-1:0]   s_rd_p0;

  logic              accept;
  logic              drain;
  logic              m_load;
  logic [CNT_W-1:0]  bub_cnt_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // With the skid buffer, in_ready depends only on local state, never on out_ready
  assign in_ready = (SKID != 0) ? (!s_vld_p0 && !flush)
                                : ((!m_vld_p0 || out_ready) && !flush);
  assign accept   = in_valid && in_ready;
  assign drain    = m_vld_p0 && out_ready;
  assign m_load   = accept && (!m_vld_p0 || out_ready);

  // ---- main entry M: drives the downstream stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_p0  <= 1'b0;
      m_ctrl_p0 <= '0;
      m_data_p0 <= '0;
      m_rd_p0   <= '0;
    end else if (flush) begin
      m_vld_p0  <= 1'b0;
      m_ctrl_p0 <= '0;
      m_rd_p0   <= '0;
    end else if (s_vld_p0 && drain) begin
      m_vld_p0  <= 1'b1;
      m_ctrl_p0 <= s_ctrl_p0;
      m_data_p0 <= s_data_p0;
      m_rd_p0   <= s_rd_p0;
    end else if (m_load) begin
      m_vld_p0  <= 1'b1;
      m_ctrl_p0 <= in_ctrl;
      m_data_p0 <= in_data;
      m_rd_p0   <= in_rd;
    end else if (drain) begin
      m_vld_p0  <= 1'b0;
      m_ctrl_p0 <= '0;
      m_rd_p0   <= '0;
    end
  end

  // ---- skid entry S: always the younger entry behind M ----
  if (SKID != 0) begin : g_skid
    logic s_load;
    assign s_load = accept && m_vld_p0 && !out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        s_vld_p0  <= 1'b0;
        s_ctrl_p0 <= '0;
        s_data_p0 <= '0;
        s_rd_p0   <= '0;
      end else if (flush || (s_vld_p0 && drain)) begin
        s_vld_p0  <= 1'b0;
        s_ctrl_p0 <= '0;
        s_rd_p0   <= '0;
      end else if (s_load) begin
        s_vld_p0  <= 1'b1;
        s_ctrl_p0 <= in_ctrl;
        s_data_p0 <= in_data;
        s_rd_p0   <= in_rd;
      end
    end
  end else begin : g_noskid
    assign s_vld_p0  = 1'b0;
    assign s_ctrl_p0 = '0;
    assign s_data_p0 = '0;
    assign s_rd_p0   = '0;
  end

  // ---- bubble counter ----
  always_ff @(posedge clk) begin
    if (rst)
      bub_cnt_p0 <= '0;
    else if (out_ready && !m_vld_p0)
      bub_cnt_p0 <= sat_inc(bub_cnt_p0);
  end

  assign out_valid    = m_vld_p0;
  assign out_ctrl     = m_ctrl_p0;
  assign out_data     = m_data_p0;
  assign out_rd       = m_rd_p0;
  assign bubble_count = bub_cnt_p0;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a SKID=1 instance and a SKID=0 instance.
module tb_pipe_stage_skid_reg;

  localparam int CW = 16;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int EW = CW + DW + RW;
  typedef logic [EW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [RW-1:0] in_rd, out_rd;
  logic [3:0]    bubble_count;

  logic          z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [CW-1:0] z_in_ctrl, z_out_ctrl;
  logic [DW-1:0] z_in_data, z_out_data;
  logic [RW-1:0] z_in_rd, z_out_rd;
  logic [3:0]    z_bubble_count;

  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .SKID(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_rd(out_rd),
    .bubble_count(bubble_count)
  );

  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .SKID(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_ctrl(z_in_ctrl), .in_data(z_in_data), .in_rd(z_in_rd),
    .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_ctrl(z_out_ctrl), .out_data(z_out_data), .out_rd(z_out_rd),
    .bubble_count(z_bubble_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboards and bubble-count models, evaluated between edges
  ent_t       sbq[$];
  ent_t       zq[$];
  ent_t       e, ze;
  logic [3:0] exp_bub, z_exp_bub;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      exp_bub = 4'd0;
    end else begin
      chk("bubble_count", 256'(bubble_count), 256'(exp_bub));
      if (!out_valid) begin
        chk("bubble_ctrl", 256'(out_ctrl), '0);
        chk("bubble_rd", 256'(out_rd), '0);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("sb_unexpected", 256'(1), '0);
        else begin
          e = sbq.pop_front();
          chk("sb_out", 256'({out_ctrl, out_data, out_rd}), 256'(e));
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) sbq.push_back({in_ctrl, in_data, in_rd});
      if (out_ready && !out_valid && exp_bub != 4'hF) exp_bub++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      zq.delete();
      z_exp_bub = 4'd0;
    end else begin
      chk("z_bubble_count", 256'(z_bubble_count), 256'(z_exp_bub));
      if (!z_out_valid) begin
        chk("z_bubble_ctrl", 256'(z_out_ctrl), '0);
        chk("z_bubble_rd", 256'(z_out_rd), '0);
      end
      if (z_out_valid && z_out_ready) begin
        if (zq.size() == 0) chk("z_sb_unexpected", 256'(1), '0);
        else begin
          ze = zq.pop_front();
          chk("z_sb_out", 256'({z_out_ctrl, z_out_data, z_out_rd}), 256'(ze));
        end
      end
      if (z_flush) zq.delete();
      else if (z_in_valid && z_in_ready) zq.push_back({z_in_ctrl, z_in_data, z_in_rd});
      if (z_out_ready && !z_out_valid && z_exp_bub != 4'hF) z_exp_bub++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [CW-1:0] c, input logic [RW-1:0] r);
    in_valid = v;
    in_ctrl  = c;
    in_data  = {$urandom, $urandom};
    in_rd    = r;
  endtask

  task automatic zput(input logic v, input logic [CW-1:0] c, input logic [RW-1:0] r);
    z_in_valid = v;
    z_in_ctrl  = c;
    z_in_data  = {$urandom, $urandom};
    z_in_rd    = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [DW-1:0] d_a;
  logic          acc;

  initial begin
    rst = 1'b1;
    flush = 1'b0; out_ready = 1'b0;
    z_flush = 1'b0; z_out_ready = 1'b0;
    put(1'b1, 16'h1234, 5'd3);
    zput(1'b1, 16'h4321, 5'd4);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    z_in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), '0);
    chk("rst_out_ctrl", 256'(out_ctrl), '0);
    chk("rst_out_rd", 256'(out_rd), '0);
    chk("rst_bubble", 256'(bubble_count), '0);
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_z_in_ready", 256'(z_in_ready), 256'(1));
    step();

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      put(1'b1, CW'(i), RW'(i));
      @(negedge clk);
      chk("stream_in_ready", 256'(in_ready), 256'(1));
      if (i > 1) begin
        chk("stream_out_valid", 256'(out_valid), 256'(1));
        chk("stream_out_ctrl", 256'(out_ctrl), 256'(i - 1));
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_ctrl", 256'(out_ctrl), 256'(4));
    step();
    @(negedge clk);
    chk("stream_empty", 256'(out_valid), '0);
    step();

    // Backpressure into the skid entry
    out_ready = 1'b0;
    put(1'b1, 16'h000A, 5'd10);
    @(negedge clk); chk("bp_ready_a", 256'(in_ready), 256'(1));
    step();
    put(1'b1, 16'h000B, 5'd11);
    @(negedge clk); chk("bp_ready_b", 256'(in_ready), 256'(1));
    chk("bp_m_a", 256'(out_ctrl), 256'(16'h000A));
    step();
    put(1'b1, 16'h000C, 5'd12);
    @(negedge clk); chk("bp_ready_full", 256'(in_ready), '0);
    step();
    @(negedge clk); chk("bp_ready_hold", 256'(in_ready), '0);
    chk("bp_m_hold", 256'(out_ctrl), 256'(16'h000A));
    step();
    out_ready = 1'b1;
    @(negedge clk); chk("bp_drain_a", 256'(out_ctrl), 256'(16'h000A));
    step();
    @(negedge clk); chk("bp_drain_b", 256'(out_ctrl), 256'(16'h000B));
    chk("bp_ready_reopen", 256'(in_ready), 256'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("bp_drain_c", 256'(out_ctrl), 256'(16'h000C));
    chk("bp_valid_c", 256'(out_valid), 256'(1));
    step();
    @(negedge clk); chk("bp_empty", 256'(out_valid), '0);
    step();

    // Flush with M and S full
    out_ready = 1'b0;
    put(1'b1, 16'hFFFF, 5'd7);
    d_a = in_data;
    step();
    put(1'b1, 16'h0B0B, 5'd8);
    step();
    put(1'b1, 16'h0C0C, 5'd9);
    flush = 1'b1;
    @(negedge clk); chk("flush_in_ready", 256'(in_ready), '0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 256'(out_valid), '0);
    chk("flush_ctrl", 256'(out_ctrl), '0);
    chk("flush_rd", 256'(out_rd), '0);
    chk("flush_data_kept", 256'(out_data), 256'(d_a));
    chk("flush_s_empty", 256'(in_ready), 256'(1));
    step();
    @(negedge clk); chk("flush_not_consumed", 256'(out_valid), '0);
    step();

    // Flush on the same edge as a drain
    put(1'b1, 16'h00EE, 5'd14);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk); chk("flush_drain_valid", 256'(out_valid), '0);
    step();

    // Mid-operation reset with both entries full
    out_ready = 1'b0;
    put(1'b1, 16'h0101, 5'd1);
    step();
    put(1'b1, 16'h0202, 5'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
    chk("mid_rst_valid", 256'(out_valid), '0);
    chk("mid_rst_bubble", 256'(bubble_count), '0);
    step();

    // Bubble counter saturation
    out_ready = 1'b1;
    repeat (10) step();
    @(negedge clk); chk("bubble_10", 256'(bubble_count), 256'(10));
    repeat (10) step();
    @(negedge clk); chk("bubble_sat", 256'(bubble_count), 256'(15));
    step();

    // SKID=0 instance: combinational in_ready
    z_out_ready = 1'b0;
    zput(1'b1, 16'h00A1, 5'd21);
    @(negedge clk); chk("z_ready_empty", 256'(z_in_ready), 256'(1));
    step();
    zput(1'b1, 16'h00B2, 5'd22);
    @(negedge clk); chk("z_ready_full", 256'(z_in_ready), '0);
    step();
    z_out_ready = 1'b1;
    @(negedge clk); chk("z_ready_comb", 256'(z_in_ready), 256'(1));
    chk("z_out_a", 256'(z_out_ctrl), 256'(16'h00A1));
    step();
    z_in_valid = 1'b0;
    @(negedge clk); chk("z_out_b", 256'(z_out_ctrl), 256'(16'h00B2));
    chk("z_valid_b", 256'(z_out_valid), 256'(1));
    step();
    @(negedge clk); chk("z_empty", 256'(z_out_valid), '0);
    step();
    z_out_ready = 1'b0;
    zput(1'b1, 16'h00C3, 5'd23);
    step();
    z_flush = 1'b1;
    @(negedge clk); chk("z_flush_ready", 256'(z_in_ready), '0);
    step();
    z_flush = 1'b0;
    z_in_valid = 1'b0;
    @(negedge clk); chk("z_flush_valid", 256'(z_out_valid), '0);
    step();

    // Random traffic on both instances, upstream holds while stalled
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (!in_valid || acc) put(1'($urandom_range(0, 1)), CW'($urandom), RW'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      if (!z_in_valid || !z_in_ready)
        if (!z_in_valid) zput(1'($urandom_range(0, 1)), CW'($urandom), RW'($urandom));
      z_out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    step();
    in_valid = 1'b0;
    z_in_valid = 1'b0;
    out_ready = 1'b1;
    z_out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("sb_drained", 256'(sbq.size()), '0);
    chk("z_sb_drained", 256'(zq.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
